// File: rtl/step_pkg.sv
// step_pkg: shared constants for the stepper step/direction generator.
//   - FSM state encodings (IDLE, SETUP, HIGH, LOW, DONE)
//   - default widths for the period counter and step count
//   - clamp_period(): raises a requested period to the minimum legal value
package step_pkg;

  localparam int unsigned DEF_CNT_W   = 28;
  localparam int unsigned DEF_STEPS_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // A step needs at least one LOW cycle after the HIGH time.
  function automatic logic [63:0] clamp_period(input logic [63:0] period_req,
                                               input logic [63:0] min_period);
    return (period_req < min_period) ? min_period : period_req;
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter with terminal-count flag.
// Loading value N makes tc_o assert N cycles after the load edge, so an
// interval of L cycles is timed by loading L-1.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count cleared)
//   load_i     : load load_val_i on the next edge
//   load_val_i : value to load
//   tc_o       : count is zero
module step_timer #(
  parameter int unsigned W = 28
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: stepper-motor step/direction generator.
// Emits num_steps pulses, each HIGH_CYCLES high within a period of
// max(period, HIGH_CYCLES+1) cycles, with direction latched at start.
// Optional macro STEP_DIR_SETUP_EN inserts DIR_SETUP (>=1) cycles of
// direction setup before the first pulse.
//   clock_in   : system clock
//   reset      : synchronous active-high reset
//   start      : request a move (sampled only in IDLE, ignored with abort)
//   num_steps  : pulse count, latched on accepted start
//   dir_in     : direction, latched on accepted start
//   period     : cycles per step, latched (clamped) on accepted start
//   abort      : end the current move through DONE
//   step_out   : registered step pulse
//   dir_out    : registered direction
//   busy       : move in progress, including the done cycle
//   done       : one-cycle completion/abort pulse
//   steps_left : registered remaining pulse count
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int unsigned CNT_W       = step_pkg::DEF_CNT_W,
  parameter int unsigned STEPS_W     = step_pkg::DEF_STEPS_W,
  parameter int unsigned HIGH_CYCLES = 1001,
  parameter int unsigned DIR_SETUP   = 100
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               start,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic               dir_in,
  input  logic [CNT_W-1:0]   period,
  input  logic               abort,
  output logic               step_out,
  output logic               dir_out,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps_left
);

  localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LEN   = CNT_W'(HIGH_CYCLES);
  localparam logic [63:0]      MIN_PERIOD = 64'(HIGH_CYCLES) + 64'd1;
`ifdef STEP_DIR_SETUP_EN
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
`endif

  logic [2:0]         state_q, state_d;
  logic [STEPS_W-1:0] steps_left_q, steps_left_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               step_q, busy_q, done_q;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_tc;

  logic [CNT_W-1:0]   period_eff;
  logic [CNT_W-1:0]   low_load;
  logic [STEPS_W-1:0] steps_dec;

  assign period_eff = CNT_W'(clamp_period(64'(period), MIN_PERIOD));
  // period_q >= HIGH_CYCLES+1, so the LOW interval is at least one cycle.
  assign low_load   = period_q - HIGH_LEN - CNT_W'(1);
  assign steps_dec  = (steps_left_q == '0) ? '0 : steps_left_q - STEPS_W'(1);

  step_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i      (clock_in),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    dir_d        = dir_q;
    period_d     = period_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          steps_left_d = num_steps;
          dir_d        = dir_in;
          period_d     = period_eff;
          if (num_steps == '0) begin
            state_d = ST_DONE;
          end else begin
`ifdef STEP_DIR_SETUP_EN
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LOAD;
`else
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = HIGH_LOAD;
`endif
          end
        end
      end
`ifdef STEP_DIR_SETUP_EN
      ST_SETUP: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (tmr_tc) begin
          state_d  = ST_HIGH;
          tmr_load = 1'b1;
          tmr_val  = HIGH_LOAD;
        end
      end
`endif
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (tmr_tc) begin
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = low_load;
        end
      end
      ST_LOW: begin
        // Abort wins over the step-complete decrement on the last LOW cycle.
        if (abort) begin
          state_d = ST_DONE;
        end else if (tmr_tc) begin
          steps_left_d = steps_dec;
          if (steps_dec == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = HIGH_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      steps_left_q <= '0;
      dir_q        <= 1'b0;
      period_q     <= '0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      dir_q        <= dir_d;
      period_q     <= period_d;
      step_q       <= (state_d == ST_HIGH);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign step_out   = step_q;
  assign dir_out    = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed scenarios for step_pulse_gen, checked every
// cycle against an arithmetic model of the move timeline, plus literal
// expectations per scenario. Honours STEP_DIR_SETUP_EN.
module tb_step_pulse_gen;

  localparam int unsigned CW = 16;
  localparam int unsigned SW = 8;
  localparam int          H  = 2;
  localparam int          DS = 4;
`ifdef STEP_DIR_SETUP_EN
  localparam int S = DS;
`else
  localparam int S = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          dir_in = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] num = '0;
  logic [CW-1:0] per = '0;

  logic          step_out, dir_out, busy, done;
  logic [SW-1:0] steps_left;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .CNT_W       (CW),
    .STEPS_W     (SW),
    .HIGH_CYCLES (H),
    .DIR_SETUP   (DS)
  ) dut (
    .clock_in   (clk),
    .reset      (rst),
    .start      (start),
    .num_steps  (num),
    .dir_in     (dir_in),
    .period     (per),
    .abort      (abort),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a move is described by its accept cycle, count, effective period
  // and done cycle; every output follows from those by arithmetic.
  int cyc = 0;
  bit m_active = 1'b0;
  int m_t0 = 0, m_n = 0, m_pe = 1, m_done = 0, m_slfin = 0;
  bit m_dir = 1'b0;

  function automatic int steps_at(input int c);
    int k, r;
    k = c - (m_t0 + 1 + S);
    if (k < 0) return m_n;
    r = m_n - k / m_pe;
    return (r < 0) ? 0 : r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_dir    = 1'b0;
      m_slfin  = 0;
    end else if (!m_active || cyc > m_done) begin
      if (start && !abort) begin
        m_active = 1'b1;
        m_t0     = cyc;
        m_n      = int'(num);
        m_dir    = dir_in;
        m_pe     = (int'(per) > H) ? int'(per) : H + 1;
        m_slfin  = 0;
        m_done   = (m_n == 0) ? cyc + 1 : cyc + 1 + S + m_n * m_pe;
      end
    end else if (cyc < m_done && abort) begin
      m_slfin = steps_at(cyc);
      m_done  = cyc + 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit idle;
      int k;
      bit e_step, e_busy, e_done;
      int e_sl;
      idle   = !m_active || cyc > m_done;
      k      = cyc - (m_t0 + 1 + S);
      e_busy = !idle;
      e_done = !idle && cyc == m_done;
      e_step = !idle && cyc < m_done && k >= 0 && (k % m_pe) < H;
      e_sl   = (idle || cyc == m_done) ? m_slfin : steps_at(cyc);
      chk($sformatf("step_out@%0d", cyc), 32'(step_out), 32'(e_step));
      chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e_busy));
      chk($sformatf("done@%0d", cyc), 32'(done), 32'(e_done));
      chk($sformatf("dir_out@%0d", cyc), 32'(dir_out), 32'(m_dir));
      chk($sformatf("steps_left@%0d", cyc), 32'(steps_left), 32'(e_sl));
    end
  end

  logic [31:0]   r_so, r_bz, r_dn, r_dr;
  logic [SW-1:0] r_sl [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 issues the start; restart_at issues a second start (n=1, dir=0,
  // period=4) that must be ignored while busy and accepted when idle.
  task automatic run_scn(input int n, input bit d, input int p, input int abort_at,
                         input int reset_at, input int restart_at,
                         input bit abort_with_start, input int ncyc);
    r_so = '0; r_bz = '0; r_dn = '0; r_dr = '0;
    for (int i = 0; i < 32; i++) r_sl[i] = '0;
    for (int c = 0; c < ncyc; c++) begin
      r_so[c] = step_out;
      r_bz[c] = busy;
      r_dn[c] = done;
      r_dr[c] = dir_out;
      r_sl[c] = steps_left;
      start = (c == 0) || (c == restart_at);
      if (c == 0) begin
        num = SW'(n); dir_in = d; per = CW'(p);
      end else if (c == restart_at) begin
        num = SW'(1); dir_in = 1'b0; per = CW'(4);
      end
      abort = (c == abort_at) || (c == 0 && abort_with_start);
      rst   = (c == reset_at);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset step_out", 32'(step_out), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset dir_out", 32'(dir_out), 32'h0);
    chk("reset steps_left", 32'(steps_left), 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // A: three steps of period 5, ignored start at cycle 8.
    run_scn(3, 1'b1, 5, -1, -1, 8, 1'b0, 24);
    chk("A step pattern", r_so, 32'h18C6 << S);
    chk("A busy span", r_bz, (32'h1 << (17 + S)) - 32'h2);
    chk("A done cycle", r_dn, 32'h1 << (16 + S));
    chk("A dir cycle1", 32'(r_dr[1]), 32'h1);
    chk("A steps_left after 1st", 32'(r_sl[6 + S]), 32'h2);
    chk("A steps_left after 2nd", 32'(r_sl[11 + S]), 32'h1);
    chk("A steps_left final", 32'(r_sl[16 + S]), 32'h0);

    // B: period 1 clamped to 3.
    run_scn(2, 1'b0, 1, -1, -1, -1, 1'b0, 14);
    chk("B clamped pattern", r_so, 32'h36 << S);
    chk("B done cycle", r_dn, 32'h1 << (7 + S));

    // C: zero steps.
    run_scn(0, 1'b1, 5, -1, -1, -1, 1'b0, 4);
    chk("C no steps", r_so, 32'h0);
    chk("C done cycle", r_dn, 32'h2);
    chk("C busy span", r_bz, 32'h2);

    // D: abort at cycle 7.
    run_scn(3, 1'b0, 5, 7, -1, -1, 1'b0, 14);
`ifdef STEP_DIR_SETUP_EN
    chk("D step pattern", r_so, 32'h60);
    chk("D steps_left", 32'(r_sl[8]), 32'h3);
`else
    chk("D step pattern", r_so, 32'hC6);
    chk("D steps_left", 32'(r_sl[8]), 32'h2);
`endif
    chk("D done cycle", r_dn, 32'h100);
    chk("D busy span", r_bz, 32'h1FE);

    // E: start together with abort in IDLE is ignored.
    run_scn(3, 1'b1, 5, -1, -1, -1, 1'b1, 4);
    chk("E no busy", r_bz, 32'h0);
    chk("E dir held", 32'(r_dr[3]), 32'h0);

    // F: reset at cycle 6, then a fresh start at cycle 9.
    run_scn(3, 1'b1, 5, -1, 6, 9, 1'b0, 24);
    chk("F outputs cleared", {28'h0, r_so[7], r_bz[7], r_dn[7], r_dr[7]}, 32'h0);
    chk("F steps_left cleared", 32'(r_sl[7]), 32'h0);
    chk("F no done before restart", r_dn & 32'h3FF, 32'h0);
    chk("F restart busy", 32'(r_bz[10]), 32'h1);
    chk("F restart done", 32'(r_dn[14 + S]), 32'h1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
